// File: rtl/mesh_term_proto_chk.sv
// Protocol checker for all mesh terminal ports: per-terminal egress/ingress handshake FSMs,
// prioritised error event reporting, sticky per-code flags and saturating counters.
module mesh_term_proto_chk #(
   parameter int ROWS      = 4,
   parameter int COLUMS    = 4,
   parameter int pckg_sz   = 32,
   parameter int TIMEOUT   = 16,
   parameter int MULTI_PKT = 1,
   parameter int CNT_W     = 16,
   localparam int NTERM    = ROWS*2 + COLUMS*2,
   localparam int TW       = (NTERM > 1) ? $clog2(NTERM) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NTERM-1:0]         pndng,
   input  logic [NTERM*pckg_sz-1:0] data_out,
   input  logic [NTERM-1:0]         popin,
   input  logic [NTERM-1:0]         pndng_i_in,
   input  logic [NTERM*pckg_sz-1:0] data_out_i_in,
   input  logic [NTERM-1:0]         pop,
   input  logic                     clr_err,
   output logic                     err_valid,
   output logic [TW-1:0]            err_term,
   output logic [2:0]               err_code,
   output logic [6:0]               err_sticky,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [CNT_W-1:0]         egr_pkt_cnt,
   output logic [CNT_W-1:0]         ing_pkt_cnt
);

   typedef enum logic {StIdle, StPend} ch_st_e;

   localparam logic [15:0] TO_LAT = 16'(TIMEOUT);

   logic [NTERM-1:0][6:0] w_viol;   // bit c-1 flags code c on that terminal
   logic [NTERM-1:0]      w_egr_hs;
   logic [NTERM-1:0]      w_ing_hs;

   genvar t;
   generate
      for (t = 0; t < NTERM; t++) begin : g_term
         logic [pckg_sz-1:0] w_eg_data, w_in_data;
         ch_st_e             r_eg_st, w_eg_st_nxt, r_in_st, w_in_st_nxt;
         logic [pckg_sz-1:0] r_eg_cap, w_eg_cap_nxt, r_in_cap, w_in_cap_nxt;
         logic               r_jp, w_jp_nxt;
         logic [15:0]        r_lat, w_lat_nxt;
         logic [6:0]         w_v;

         assign w_eg_data   = data_out[t*pckg_sz +: pckg_sz];
         assign w_in_data   = data_out_i_in[t*pckg_sz +: pckg_sz];
         assign w_egr_hs[t] = pndng[t] & popin[t];
         assign w_ing_hs[t] = pndng_i_in[t] & pop[t];
         assign w_viol[t]   = w_v;

         always_comb begin
            w_eg_st_nxt  = r_eg_st;
            w_eg_cap_nxt = r_eg_cap;
            w_jp_nxt     = 1'b0;
            w_in_st_nxt  = r_in_st;
            w_in_cap_nxt = r_in_cap;
            w_lat_nxt    = r_lat;
            w_v          = '0;
            w_v[1]       = popin[t] & ~pndng[t];
            w_v[2]       = (MULTI_PKT == 0) && r_jp && pndng[t];
            w_v[5]       = pop[t] & ~pndng_i_in[t];

            unique case (r_eg_st)
               StIdle: begin
                  if (pndng[t]) begin
                     if (popin[t]) begin
                        w_jp_nxt = 1'b1;
                     end else begin
                        w_eg_cap_nxt = w_eg_data;
                        w_eg_st_nxt  = StPend;
                     end
                  end
               end
               StPend: begin
                  if (!pndng[t]) begin
                     w_v[3]      = ~popin[t];
                     w_eg_st_nxt = StIdle;
                  end else if (popin[t]) begin
                     w_v[0]      = (w_eg_data != r_eg_cap);
                     w_jp_nxt    = 1'b1;
                     w_eg_st_nxt = StIdle;
                  end else if (w_eg_data != r_eg_cap) begin
                     w_v[0]       = 1'b1;
                     w_eg_cap_nxt = w_eg_data;
                  end
               end
            endcase

            unique case (r_in_st)
               StIdle: begin
                  if (pndng_i_in[t] && !pop[t]) begin
                     w_in_cap_nxt = w_in_data;
                     w_lat_nxt    = 16'd1;
                     w_in_st_nxt  = StPend;
                     w_v[6]       = (TO_LAT == 16'd1);
                  end
               end
               StPend: begin
                  if (!pndng_i_in[t]) begin
                     w_in_st_nxt = StIdle;
                     w_lat_nxt   = '0;
                  end else if (pop[t]) begin
                     w_v[4]      = (w_in_data != r_in_cap);
                     w_in_st_nxt = StIdle;
                     w_lat_nxt   = '0;
                  end else begin
                     if (w_in_data != r_in_cap) begin
                        w_v[4]       = 1'b1;
                        w_in_cap_nxt = w_in_data;
                     end
                     if (r_lat != 16'hFFFF) w_lat_nxt = r_lat + 16'd1;
                     // equality is reached once since lat only climbs while pending
                     w_v[6] = (r_lat != TO_LAT) && (w_lat_nxt == TO_LAT);
                  end
               end
            endcase
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               r_eg_st  <= StIdle;
               r_eg_cap <= '0;
               r_jp     <= 1'b0;
               r_in_st  <= StIdle;
               r_in_cap <= '0;
               r_lat    <= '0;
            end else begin
               r_eg_st  <= w_eg_st_nxt;
               r_eg_cap <= w_eg_cap_nxt;
               r_jp     <= w_jp_nxt;
               r_in_st  <= w_in_st_nxt;
               r_in_cap <= w_in_cap_nxt;
               r_lat    <= w_lat_nxt;
            end
         end
      end
   endgenerate

   logic             w_any;
   logic [TW-1:0]    w_term;
   logic [2:0]       w_code;
   logic [6:0]       w_or;
   logic [CNT_W:0]   w_egr_add, w_ing_add, w_err_sum, w_egr_sum, w_ing_sum;
   logic [CNT_W-1:0] w_err_base, w_egr_base, w_ing_base;

   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] s);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Descending scans so the lowest terminal, then lowest code, is written last.
   always_comb begin
      w_term    = '0;
      w_code    = '0;
      w_or      = '0;
      w_egr_add = '0;
      w_ing_add = '0;
      for (int i = NTERM - 1; i >= 0; i--) begin
         w_or      = w_or | w_viol[i];
         w_egr_add = w_egr_add + (CNT_W+1)'(w_egr_hs[i]);
         w_ing_add = w_ing_add + (CNT_W+1)'(w_ing_hs[i]);
         if (w_viol[i] != '0) begin
            w_term = TW'(i);
            for (int c = 7; c >= 1; c--) begin
               if (w_viol[i][c-1]) w_code = 3'(c);
            end
         end
      end
      w_any      = |w_or;
      w_err_base = clr_err ? '0 : err_cnt;
      w_egr_base = clr_err ? '0 : egr_pkt_cnt;
      w_ing_base = clr_err ? '0 : ing_pkt_cnt;
      w_err_sum  = {1'b0, w_err_base} + (CNT_W+1)'(w_any);
      w_egr_sum  = {1'b0, w_egr_base} + w_egr_add;
      w_ing_sum  = {1'b0, w_ing_base} + w_ing_add;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_valid   <= 1'b0;
         err_term    <= '0;
         err_code    <= '0;
         err_sticky  <= '0;
         err_cnt     <= '0;
         egr_pkt_cnt <= '0;
         ing_pkt_cnt <= '0;
      end else begin
         err_valid   <= w_any;
         err_term    <= w_term;
         err_code    <= w_code;
         err_sticky  <= (clr_err ? 7'd0 : err_sticky) | w_or;
         err_cnt     <= sat(w_err_sum);
         egr_pkt_cnt <= sat(w_egr_sum);
         ing_pkt_cnt <= sat(w_ing_sum);
      end
   end

endmodule

// File: tb/tb_mesh_term_proto_chk.sv
// Directed bench for mesh_term_proto_chk: default, MULTI_PKT=0 and narrow-counter instances
// share one stimulus stream; outputs are sampled 1 time unit after each rising edge.
module tb_mesh_term_proto_chk;

   localparam int NT = 16;
   localparam int PW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [NT-1:0]   pndng, popin, pndng_i_in, pop;
   logic [NT*PW-1:0] data_out, data_out_i_in;
   logic            clr_err;

   logic            err_valid, err_valid0, err_valid_s;
   logic [3:0]      err_term, err_term0, err_term_s;
   logic [2:0]      err_code, err_code0, err_code_s;
   logic [6:0]      err_sticky, err_sticky0, err_sticky_s;
   logic [15:0]     err_cnt, egr_pkt_cnt, ing_pkt_cnt;
   logic [15:0]     err_cnt0, egr_pkt_cnt0, ing_pkt_cnt0;
   logic [1:0]      err_cnt_s, egr_pkt_cnt_s, ing_pkt_cnt_s;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mesh_term_proto_chk u_dut (
      .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .popin(popin),
      .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .pop(pop), .clr_err(clr_err),
      .err_valid(err_valid), .err_term(err_term), .err_code(err_code),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .egr_pkt_cnt(egr_pkt_cnt),
      .ing_pkt_cnt(ing_pkt_cnt)
   );

   mesh_term_proto_chk #(.MULTI_PKT(0)) u_dut0 (
      .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .popin(popin),
      .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .pop(pop), .clr_err(clr_err),
      .err_valid(err_valid0), .err_term(err_term0), .err_code(err_code0),
      .err_sticky(err_sticky0), .err_cnt(err_cnt0), .egr_pkt_cnt(egr_pkt_cnt0),
      .ing_pkt_cnt(ing_pkt_cnt0)
   );

   mesh_term_proto_chk #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .popin(popin),
      .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .pop(pop), .clr_err(clr_err),
      .err_valid(err_valid_s), .err_term(err_term_s), .err_code(err_code_s),
      .err_sticky(err_sticky_s), .err_cnt(err_cnt_s), .egr_pkt_cnt(egr_pkt_cnt_s),
      .ing_pkt_cnt(ing_pkt_cnt_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pndng         = '0;
      popin         = '0;
      pndng_i_in    = '0;
      pop           = '0;
      data_out      = '0;
      data_out_i_in = '0;
      clr_err       = 1'b0;
   endtask

   task automatic clear_errs();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   int n_ev;
   int ev_at;
   logic [2:0] ev_code;
   logic [3:0] ev_term;

   initial begin
      // Reset with random inputs
      reset      = 1'b0;
      pndng      = 16'($urandom);
      popin      = 16'($urandom);
      pndng_i_in = 16'($urandom);
      pop        = 16'($urandom);
      clr_err    = 1'($urandom);
      for (int i = 0; i < NT; i++) begin
         data_out[i*PW +: PW]      = $urandom;
         data_out_i_in[i*PW +: PW] = $urandom;
      end
      tick();
      tick();
      check("rst_valid", 64'(err_valid), 64'd0);
      check("rst_term", 64'(err_term), 64'd0);
      check("rst_code", 64'(err_code), 64'd0);
      check("rst_sticky", 64'(err_sticky), 64'd0);
      check("rst_errcnt", 64'(err_cnt), 64'd0);
      check("rst_egr", 64'(egr_pkt_cnt), 64'd0);
      check("rst_ing", 64'(ing_pkt_cnt), 64'd0);

      idle_inputs();
      reset = 1'b1;
      tick();
      check("post_rst_valid", 64'(err_valid), 64'd0);

      // Terminal 3 enters PEND silently; withdrawing proves the pending state
      pndng[3] = 1'b1;
      tick();
      check("t3_pend_noerr", 64'(err_valid), 64'd0);
      pndng[3] = 1'b0;
      tick();
      check("t3_wd_valid", 64'(err_valid), 64'd1);
      check("t3_wd_term", 64'(err_term), 64'd3);
      check("t3_wd_code", 64'(err_code), 64'd4);
      check("t3_wd_sticky", 64'(err_sticky), 64'h08);
      clear_errs();
      check("clr_sticky", 64'(err_sticky), 64'd0);
      check("clr_errcnt", 64'(err_cnt), 64'd0);

      // Terminal 5 egress data changes before popin
      pndng[5] = 1'b1;
      data_out[5*PW +: PW] = 32'hA5A5A5A5;
      tick();
      check("t5_pend_noerr", 64'(err_valid), 64'd0);
      data_out[5*PW +: PW] = 32'h5A5A5A5A;
      tick();
      check("t5_valid", 64'(err_valid), 64'd1);
      check("t5_term", 64'(err_term), 64'd5);
      check("t5_code", 64'(err_code), 64'd1);
      check("t5_sticky", 64'(err_sticky), 64'h01);
      check("t5_errcnt", 64'(err_cnt), 64'd1);
      popin[5] = 1'b1;
      tick();
      check("t5_pop_noerr", 64'(err_valid), 64'd0);
      check("t5_egr", 64'(egr_pkt_cnt), 64'd1);
      idle_inputs();
      tick();
      check("t5_idle_noerr", 64'(err_valid), 64'd0);
      clear_errs();

      // Terminal 0 ingress timeout, then pop on the 20th edge
      n_ev = 0;
      ev_at = 0;
      ev_code = '0;
      ev_term = '1;
      pndng_i_in[0] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 20) pop[0] = 1'b1;
         tick();
         if (err_valid) begin
            n_ev++;
            ev_at   = i;
            ev_code = err_code;
            ev_term = err_term;
         end
      end
      check("to_events", 64'(n_ev), 64'd1);
      check("to_edge", 64'(ev_at), 64'd16);
      check("to_code", 64'(ev_code), 64'd7);
      check("to_term", 64'(ev_term), 64'd0);
      check("to_ing", 64'(ing_pkt_cnt), 64'd1);
      check("to_errcnt", 64'(err_cnt), 64'd1);
      idle_inputs();
      tick();
      check("to_after", 64'(err_valid), 64'd0);

      // Same-edge violations on terminals 2 (code 2) and 1 (code 6)
      popin[2] = 1'b1;
      pop[1]   = 1'b1;
      tick();
      check("multi_valid", 64'(err_valid), 64'd1);
      check("multi_term", 64'(err_term), 64'd1);
      check("multi_code", 64'(err_code), 64'd6);
      check("multi_sticky", 64'(err_sticky), 64'h62);
      check("multi_errcnt", 64'(err_cnt), 64'd2);
      idle_inputs();

      // clr_err together with an ingress handshake
      pndng_i_in[4] = 1'b1;
      pop[4]        = 1'b1;
      clr_err       = 1'b1;
      tick();
      check("clrhs_ing", 64'(ing_pkt_cnt), 64'd1);
      check("clrhs_errcnt", 64'(err_cnt), 64'd0);
      check("clrhs_sticky", 64'(err_sticky), 64'd0);
      idle_inputs();

      // Terminal 7: pndng held across popin
      pndng[7] = 1'b1;
      data_out[7*PW +: PW] = 32'h12345678;
      tick();
      popin[7] = 1'b1;
      tick();
      check("mp_egr1", 64'(egr_pkt_cnt), 64'd1);
      popin[7] = 1'b0;
      tick();
      check("mp0_valid", 64'(err_valid0), 64'd1);
      check("mp0_term", 64'(err_term0), 64'd7);
      check("mp0_code", 64'(err_code0), 64'd3);
      check("mp1_valid", 64'(err_valid), 64'd0);
      popin[7] = 1'b1;
      tick();
      check("mp1_egr2", 64'(egr_pkt_cnt), 64'd2);
      check("mp1_noerr", 64'(err_cnt), 64'd0);
      idle_inputs();
      tick();

      // Counter saturation on the 2-bit instance
      clear_errs();
      pndng[9] = 1'b1;
      popin[9] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("sat_egr", 64'(egr_pkt_cnt_s), 64'd3);
      check("wide_egr", 64'(egr_pkt_cnt), 64'd5);
      idle_inputs();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
